div_unit: RTL and testbench

- Multicycle 32-bit signed integer divider for the multicycle MIPS datapath. It executes the DIV instruction.
- Sits directly upstream of the HI/LO source multiplexers. Its quotient (lo_out) and remainder (hi_out) are data inputs to those muxes, which select what is written into the LO and HI registers.
- The control unit issues div_start, then waits for div_done or div_zero before advancing.

---
 rtl/div_unit.sv | 127 ++++++++++++
 tb/tb_div_unit.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Multicycle signed restoring divider (DIV): quotient on lo_out, remainder on hi_out.
// Build option DIV_EARLY_OUT_EN skips the iterations when |dividend| < |divisor|.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    div_start,
    input  logic signed [WIDTH-1:0] dividend,
    input  logic signed [WIDTH-1:0] divisor,
    output logic signed [WIDTH-1:0] lo_out,
    output logic signed [WIDTH-1:0] hi_out,
    output logic                    div_done,
    output logic                    div_zero
);

    typedef enum logic [1:0] {IDLE, BUSY, FINISH} state_t;

    localparam int CW = $clog2(WIDTH) + 1;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH:0]   rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic             neg_q_q;
    logic             neg_r_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] hi_q;
    logic             done_q;
    logic             zero_q;

    logic [WIDTH+1:0] shift_rem;
    logic [WIDTH:0]   rem_d;
    logic [WIDTH-1:0] quo_d;

    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
        logic [WIDTH-1:0] u;
        u = v;
        return v[WIDTH-1] ? (~u + 1'b1) : u;
    endfunction

    // Two's complement negation truncated to WIDTH, applied only when neg is set.
    function automatic logic [WIDTH-1:0] apply_sign(input logic neg, input logic [WIDTH-1:0] m);
        return neg ? (~m + 1'b1) : m;
    endfunction

    always_comb begin
        shift_rem = {rem_q, quo_q[WIDTH-1]};
        rem_d     = shift_rem[WIDTH:0];
        quo_d     = {quo_q[WIDTH-2:0], 1'b0};
        if (shift_rem >= {2'b00, dvs_q}) begin
            rem_d = (WIDTH+1)'(shift_rem - {2'b00, dvs_q});
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
            lo_q    <= '0;
            hi_q    <= '0;
            done_q  <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            zero_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (div_start) begin
                        if (divisor == '0) begin
                            zero_q <= 1'b1;
                        end else begin
                            dvs_q   <= magnitude(divisor);
                            neg_q_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                            neg_r_q <= dividend[WIDTH-1];
                            cnt_q   <= '0;
`ifdef DIV_EARLY_OUT_EN
                            if (magnitude(dividend) < magnitude(divisor)) begin
                                quo_q   <= '0;
                                rem_q   <= {1'b0, magnitude(dividend)};
                                state_q <= FINISH;
                            end else begin
                                quo_q   <= magnitude(dividend);
                                rem_q   <= '0;
                                state_q <= BUSY;
                            end
`else
                            quo_q   <= magnitude(dividend);
                            rem_q   <= '0;
                            state_q <= BUSY;
`endif
                        end
                    end
                end
                BUSY: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_q <= FINISH;
                    end
                end
                FINISH: begin
                    // The restored remainder is always below |divisor|, so its low WIDTH bits are exact.
                    lo_q    <= apply_sign(neg_q_q, quo_q);
                    hi_q    <= apply_sign(neg_r_q, rem_q[WIDTH-1:0]);
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign lo_out   = lo_q;
    assign hi_out   = hi_q;
    assign div_done = done_q;
    assign div_zero = zero_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed cases plus randomized operands against
// an integer-arithmetic reference (truncating division, remainder takes dividend sign).
module tb_div_unit;

    localparam int W = 32;

    logic                clk = 1'b0;
    logic                reset;
    logic                div_start;
    logic signed [W-1:0] dividend;
    logic signed [W-1:0] divisor;
    logic signed [W-1:0] lo_out;
    logic signed [W-1:0] hi_out;
    logic                div_done;
    logic                div_zero;

    int checks = 0;
    int errors = 0;

    div_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .div_start(div_start),
        .dividend (dividend),
        .divisor  (divisor),
        .lo_out   (lo_out),
        .hi_out   (hi_out),
        .div_done (div_done),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = W'(sa / sb);
        r  = W'(sa % sb);
    endfunction

    // Edges after the start edge until div_done is visible.
    function automatic int exp_lat(input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb, ma, mb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ma = (sa < 0) ? -sa : sa;
        mb = (sb < 0) ? -sb : sb;
`ifdef DIV_EARLY_OUT_EN
        if (ma < mb) return 1;
`endif
        if (ma < 0 || mb < 0) return -2;
        return W + 1;
    endfunction

    task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b, output int lat,
                          output logic done_next, output logic zero_seen);
        lat       = -1;
        zero_seen = 1'b0;
        @(negedge clk);
        dividend  = a;
        divisor   = b;
        div_start = 1'b1;
        @(negedge clk);
        div_start = 1'b0;
        for (int k = 0; k < 80; k++) begin
            if (div_zero) zero_seen = 1'b1;
            if (div_done) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        done_next = div_done;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        div_start = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({lo_out, hi_out, div_done, div_zero} !== {(2*W+2){1'b0}}) begin
            errors++;
            $display("FAIL reset_state: got lo=%h hi=%h done=%b zero=%b, expected all zero",
                     lo_out, hi_out, div_done, div_zero);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] ta [8] = '{32'd7, 32'hFFFFFFF9, 32'd7, 32'h80000000,
                                 32'hFFFFFF9C, 32'd0, 32'hFFFFFFFF, 32'h7FFFFFFF};
        logic [W-1:0] tb [8] = '{32'd2, 32'd2, 32'hFFFFFFFE, 32'hFFFFFFFF,
                                 32'hFFFFFFF9, 32'd5, 32'h80000000, 32'd1};
        logic [W-1:0] tq [8] = '{32'd3, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'h80000000,
                                 32'd14, 32'd0, 32'd0, 32'h7FFFFFFF};
        logic [W-1:0] tr [8] = '{32'd1, 32'hFFFFFFFF, 32'd1, 32'd0,
                                 32'hFFFFFFFE, 32'd0, 32'hFFFFFFFF, 32'd0};
        int lat;
        logic dn, zs;
        for (int i = 0; i < 8; i++) begin
            do_div(ta[i], tb[i], lat, dn, zs);
            checks++;
            if (lat !== exp_lat(ta[i], tb[i])) begin
                errors++;
                $display("FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, exp_lat(ta[i], tb[i]));
            end
            checks++;
            if (lo_out !== tq[i]) begin
                errors++;
                $display("FAIL directed_lo[%0d]: got %h expected %h", i, lo_out, tq[i]);
            end
            checks++;
            if (hi_out !== tr[i]) begin
                errors++;
                $display("FAIL directed_hi[%0d]: got %h expected %h", i, hi_out, tr[i]);
            end
            checks++;
            if (dn !== 1'b0 || zs !== 1'b0) begin
                errors++;
                $display("FAIL directed_pulse[%0d]: got done_next=%b zero_seen=%b expected 0 0", i, dn, zs);
            end
        end
    endtask

    task automatic test_div_zero();
        logic [W-1:0] plo, phi;
        int lat;
        logic dn, zs;
        plo = lo_out;
        phi = hi_out;
        @(negedge clk);
        dividend  = 32'd5;
        divisor   = '0;
        div_start = 1'b1;
        @(negedge clk);
        div_start = 1'b0;
        checks++;
        if ({div_zero, div_done} !== 2'b10) begin
            errors++;
            $display("FAIL zero_pulse: got zero=%b done=%b expected zero=1 done=0", div_zero, div_done);
        end
        checks++;
        if (lo_out !== plo || hi_out !== phi) begin
            errors++;
            $display("FAIL zero_hold: got lo=%h hi=%h expected lo=%h hi=%h", lo_out, hi_out, plo, phi);
        end
        @(negedge clk);
        checks++;
        if ({div_zero, div_done} !== 2'b00) begin
            errors++;
            $display("FAIL zero_width: got zero=%b done=%b expected 0 0", div_zero, div_done);
        end
        do_div(32'd9, 32'd4, lat, dn, zs);
        checks++;
        if (lat !== exp_lat(32'd9, 32'd4) || lo_out !== 32'd2 || hi_out !== 32'd1) begin
            errors++;
            $display("FAIL zero_then_div: got lat=%0d lo=%h hi=%h expected lat=%0d lo=2 hi=1",
                     lat, lo_out, hi_out, exp_lat(32'd9, 32'd4));
        end
    endtask

    task automatic test_reset_mid_op();
        int dones;
        int lat;
        logic dn, zs;
        @(negedge clk);
        dividend  = 32'd100;
        divisor   = 32'd7;
        div_start = 1'b1;
        @(negedge clk);
        div_start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({lo_out, hi_out, div_done, div_zero} !== {(2*W+2){1'b0}}) begin
            errors++;
            $display("FAIL midreset_outputs: got lo=%h hi=%h done=%b zero=%b expected all zero",
                     lo_out, hi_out, div_done, div_zero);
        end
        dones = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (div_done) dones++;
        end
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("FAIL midreset_no_done: got %0d pulses expected 0", dones);
        end
        do_div(32'd9, 32'd3, lat, dn, zs);
        checks++;
        if (lat !== W + 1 || lo_out !== 32'd3 || hi_out !== 32'd0) begin
            errors++;
            $display("FAIL midreset_next: got lat=%0d lo=%h hi=%h expected lat=%0d lo=3 hi=0",
                     lat, lo_out, hi_out, W + 1);
        end
    endtask

    task automatic test_ignore_restart();
        int dones, first;
        logic [W-1:0] glo, ghi;
        dones = 0;
        first = -1;
        glo   = '0;
        ghi   = '0;
        @(negedge clk);
        dividend  = 32'd100;
        divisor   = 32'd7;
        div_start = 1'b1;
        @(negedge clk);
        div_start = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (k == 5) begin
                dividend  = 32'd1;
                divisor   = 32'd1;
                div_start = 1'b1;
            end else begin
                div_start = 1'b0;
            end
            if (div_done) begin
                dones++;
                if (first < 0) begin
                    first = k;
                    glo   = lo_out;
                    ghi   = hi_out;
                end
            end
            @(negedge clk);
        end
        checks++;
        if (dones !== 1 || first !== W + 1) begin
            errors++;
            $display("FAIL restart_ignored: got %0d pulses first at %0d expected 1 at %0d", dones, first, W + 1);
        end
        checks++;
        if (glo !== 32'd14 || ghi !== 32'd2) begin
            errors++;
            $display("FAIL restart_result: got lo=%h hi=%h expected lo=e hi=2", glo, ghi);
        end
    endtask

    task automatic test_early_out();
        int lat;
        logic dn, zs;
        do_div(32'd3, 32'd10, lat, dn, zs);
        checks++;
        if (lat !== exp_lat(32'd3, 32'd10) || lo_out !== 32'd0 || hi_out !== 32'd3) begin
            errors++;
            $display("FAIL small_over_large: got lat=%0d lo=%h hi=%h expected lat=%0d lo=0 hi=3",
                     lat, lo_out, hi_out, exp_lat(32'd3, 32'd10));
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, q, r, plo, phi;
        int lat, mode;
        logic dn, zs;
        for (int i = 0; i < 40; i++) begin
            a    = $urandom;
            mode = $urandom_range(0, 4);
            case (mode)
                0: b = $urandom;
                1: b = W'($urandom_range(0, 20)) - 32'd10;
                2: b = '0;
                3: begin a = W'($urandom_range(0, 50)) - 32'd25; b = $urandom; end
                default: b = W'($urandom_range(1, 1000));
            endcase
            if (b == '0) begin
                plo = lo_out;
                phi = hi_out;
                @(negedge clk);
                dividend  = a;
                divisor   = b;
                div_start = 1'b1;
                @(negedge clk);
                div_start = 1'b0;
                checks++;
                if ({div_zero, div_done} !== 2'b10 || lo_out !== plo || hi_out !== phi) begin
                    errors++;
                    $display("FAIL rand_zero[%0d]: got zero=%b done=%b lo=%h hi=%h expected 1 0 %h %h",
                             i, div_zero, div_done, lo_out, hi_out, plo, phi);
                end
                @(negedge clk);
            end else begin
                model(a, b, q, r);
                do_div(a, b, lat, dn, zs);
                checks++;
                if (lat !== exp_lat(a, b) || dn !== 1'b0 || zs !== 1'b0) begin
                    errors++;
                    $display("FAIL rand_timing[%0d]: got lat=%0d next=%b zero=%b expected lat=%0d 0 0",
                             i, lat, dn, zs, exp_lat(a, b));
                end
                checks++;
                if (lo_out !== q || hi_out !== r) begin
                    errors++;
                    $display("FAIL rand_result[%0d]: %h/%h got lo=%h hi=%h expected lo=%h hi=%h",
                             i, a, b, lo_out, hi_out, q, r);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a, b, q, r;
        int lat;
        logic dn, zs;
        for (int i = 0; i < 6; i++) begin
            a = W'($urandom_range(0, 100000)) - 32'd50000;
            b = W'($urandom_range(1, 300));
            if (i[0]) b = -b;
            model(a, b, q, r);
            do_div(a, b, lat, dn, zs);
            checks++;
            if (lat !== exp_lat(a, b) || lo_out !== q || hi_out !== r) begin
                errors++;
                $display("FAIL b2b[%0d]: %h/%h got lat=%0d lo=%h hi=%h expected lat=%0d lo=%h hi=%h",
                         i, a, b, lat, lo_out, hi_out, exp_lat(a, b), q, r);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_div_zero();
        test_reset_mid_op();
        test_ignore_restart();
        test_early_out();
        test_random();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
